// File: rtl/tick_monitor.sv
// Measures the cycle distance between tick_in rising edges, flags early/late ticks
// against a NOMINAL +/- TOL window and reports lock after LOCK_N consecutive good periods.
module tick_monitor #(
   parameter int unsigned NOMINAL = 50000000,
   parameter int unsigned TOL     = 1000,
   parameter int unsigned LOCK_N  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_in,
   input  logic        clear,
   output logic [25:0] period,
   output logic        period_valid,
   output logic        locked,
   output logic        early_err,
   output logic        late_err,
   output logic [7:0]  err_count
);

   localparam logic [25:0] CNT_MAX  = 26'(NOMINAL + TOL);
   localparam logic [25:0] WIN_LO   = 26'(NOMINAL - TOL);
   localparam logic [3:0]  GOOD_TGT = 4'(LOCK_N);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t      state_q, state_d;
   logic        tick_q;
   logic [25:0] cnt_q, cnt_d;
   logic [3:0]  good_q, good_d;
   logic [25:0] period_q, period_d;
   logic        pv_q, pv_d;
   logic        locked_q, locked_d;
   logic        early_q, early_d;
   logic        late_q, late_d;
   logic [7:0]  err_q, err_d;
   logic        tick_edge;
   logic        err_inc;

   assign tick_edge = tick_in & ~tick_q;

   always_comb begin
      state_d  = state_q;
      good_d   = good_q;
      period_d = period_q;
      pv_d     = 1'b0;
      early_d  = 1'b0;
      late_d   = 1'b0;
      locked_d = locked_q;
      err_d    = err_q;
      err_inc  = 1'b0;

      if (tick_edge) begin
         cnt_d = 26'd1;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 26'd1;
      end

      case (state_q)
         IDLE: begin
            if (tick_edge) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // An edge on the saturation cycle wins over the timeout.
            if (tick_edge) begin
               period_d = cnt_q;
               pv_d     = 1'b1;
               if (cnt_q < WIN_LO) begin
                  early_d  = 1'b1;
                  good_d   = 4'd0;
                  locked_d = 1'b0;
                  err_inc  = 1'b1;
               end else begin
                  if (good_q != GOOD_TGT) begin
                     good_d = good_q + 4'd1;
                  end
                  if (good_d == GOOD_TGT) begin
                     locked_d = 1'b1;
                  end
               end
            end else if (cnt_q == CNT_MAX) begin
               late_d   = 1'b1;
               state_d  = IDLE;
               good_d   = 4'd0;
               locked_d = 1'b0;
               err_inc  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (err_inc && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end

      // Soft clear discards everything except the edge-detect history.
      if (clear) begin
         state_d  = IDLE;
         cnt_d    = 26'd0;
         good_d   = 4'd0;
         period_d = 26'd0;
         pv_d     = 1'b0;
         early_d  = 1'b0;
         late_d   = 1'b0;
         locked_d = 1'b0;
         err_d    = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         tick_q   <= 1'b0;
         cnt_q    <= 26'd0;
         good_q   <= 4'd0;
         period_q <= 26'd0;
         pv_q     <= 1'b0;
         locked_q <= 1'b0;
         early_q  <= 1'b0;
         late_q   <= 1'b0;
         err_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_in;
         cnt_q    <= cnt_d;
         good_q   <= good_d;
         period_q <= period_d;
         pv_q     <= pv_d;
         locked_q <= locked_d;
         early_q  <= early_d;
         late_q   <= late_d;
         err_q    <= err_d;
      end
   end

   assign period       = period_q;
   assign period_valid = pv_q;
   assign locked       = locked_q;
   assign early_err    = early_q;
   assign late_err     = late_q;
   assign err_count    = err_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Scoreboard bench for tick_monitor (NOMINAL=10, TOL=2, LOCK_N=3): stimulus queues the
// expected output event per tick, a negedge monitor pops and compares every DUT event.
module tb_tick_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick_in;
   logic        clear;
   logic [25:0] period;
   logic        period_valid;
   logic        locked;
   logic        early_err;
   logic        late_err;
   logic [7:0]  err_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        pv;
      logic        ee;
      logic        le;
      logic [25:0] per;
      logic        lck;
      logic [7:0]  err;
   } ev_t;

   ev_t exp_q[$];

   tick_monitor #(
      .NOMINAL(10),
      .TOL    (2),
      .LOCK_N (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick_in     (tick_in),
      .clear       (clear),
      .period      (period),
      .period_valid(period_valid),
      .locked      (locked),
      .early_err   (early_err),
      .late_err    (late_err),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   // Monitor: every cycle with an output pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (period_valid || early_err || late_err) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event_unexpected: got pv=%0b ee=%0b le=%0b period=%0d locked=%0b err=%0d, required no event",
                     period_valid, early_err, late_err, period, locked, err_count);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (period_valid !== e.pv || early_err !== e.ee || late_err !== e.le ||
                period !== e.per || locked !== e.lck || err_count !== e.err) begin
               failures++;
               $display("FAIL event: got pv=%0b ee=%0b le=%0b period=%0d locked=%0b err=%0d, required pv=%0b ee=%0b le=%0b period=%0d locked=%0b err=%0d",
                        period_valid, early_err, late_err, period, locked, err_count,
                        e.pv, e.ee, e.le, e.per, e.lck, e.err);
            end else begin
               $display("event ok: pv=%0b ee=%0b le=%0b period=%0d locked=%0b err=%0d",
                        period_valid, early_err, late_err, period, locked, err_count);
            end
         end
      end
   end

   task automatic expect_ev(input logic pv, input logic ee, input logic le,
                            input int per, input logic lck, input int err);
      ev_t e;
      e.pv  = pv;
      e.ee  = ee;
      e.le  = le;
      e.per = 26'(per);
      e.lck = lck;
      e.err = 8'(err);
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end else begin
         $display("check ok: %s = %0d", name, got);
      end
   endtask

   // One-cycle tick, then idle so the following tick lands gap cycles later.
   task automatic send(input int gap);
      tick_in = 1'b1;
      @(posedge clk);
      #1 tick_in = 1'b0;
      repeat (gap - 1) @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      tick_in = 1'b0;
      clear   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("idle_period", int'(period), 0);
      check("idle_period_valid", int'(period_valid), 0);
      check("idle_locked", int'(locked), 0);
      check("idle_early_err", int'(early_err), 0);
      check("idle_late_err", int'(late_err), 0);
      check("idle_err_count", int'(err_count), 0);

      // Five ticks at 10 cycles, then an early one at 7, then re-lock.
      send(10);
      expect_ev(1, 0, 0, 10, 0, 0); send(10);
      expect_ev(1, 0, 0, 10, 0, 0); send(10);
      expect_ev(1, 0, 0, 10, 1, 0); send(10);
      expect_ev(1, 0, 0, 10, 1, 0); send(7);
      expect_ev(1, 1, 0, 7, 0, 1);  send(10);
      expect_ev(1, 0, 0, 10, 0, 1); send(10);
      expect_ev(1, 0, 0, 10, 0, 1); send(10);
      // Lock again, then silence causes a timeout back to IDLE.
      expect_ev(1, 0, 0, 10, 1, 1);
      expect_ev(0, 0, 1, 10, 0, 2);
      send(20);
      // First tick after timeout only re-arms; next tick exactly on the window edge.
      send(12);
      expect_ev(1, 0, 0, 12, 0, 2); send(10);
      // Held-high tick counts as a single edge.
      expect_ev(1, 0, 0, 10, 0, 2);
      tick_in = 1'b1;
      repeat (5) @(posedge clk);
      #1 tick_in = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      expect_ev(1, 0, 0, 10, 1, 2);
      tick_in = 1'b1;
      @(posedge clk);
      #1 tick_in = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("rst_period", int'(period), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_err_count", int'(err_count), 0);
      check("rst_period_valid", int'(period_valid), 0);

      send(10);
      expect_ev(1, 0, 0, 10, 0, 0); send(10);
      // Clear coincides with a tick: the tick must be ignored.
      clear   = 1'b1;
      tick_in = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      tick_in = 1'b0;
      check("clear_period", int'(period), 0);
      check("clear_locked", int'(locked), 0);
      repeat (2) @(posedge clk);
      #1;
      send(10);
      expect_ev(1, 0, 0, 10, 0, 0); send(3);

      // 260 early periods drive err_count into saturation, then a timeout.
      for (int k = 1; k <= 260; k++) begin
         expect_ev(1, 1, 0, 3, 0, (k > 255) ? 255 : k);
         send(3);
      end
      expect_ev(0, 0, 1, 3, 0, 255);
      repeat (20) @(posedge clk);
      #1;
      check("sat_err_count", int'(err_count), 255);
      check("pending_events", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tick_monitor.md
TICK_MONITOR -- requirements
Module: tick_monitor

Interface
REQ-001 SHALL have parameter NOMINAL, default 50000000, meaning the expected tick period in clk cycles.
REQ-002 SHALL have parameter TOL, default 1000, meaning the allowed +/- deviation in cycles; NOMINAL+TOL < 2^26 and TOL < NOMINAL.
REQ-003 SHALL have parameter LOCK_N, default 3, meaning the number of consecutive in-window periods needed to assert locked (1..15).
REQ-004 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port tick_in  input  1  tick strobe from a tick generator, synchronous to clk.
REQ-007 SHALL have port clear  input  1  synchronous soft clear of measurement state.
REQ-008 SHALL have port period  output  26  last measured tick-to-tick period in cycles.
REQ-009 SHALL have port period_valid  output  1  one-cycle pulse when period is updated.
REQ-010 SHALL have port locked  output  1  level; consecutive in-window periods >= LOCK_N.
REQ-011 SHALL have port early_err  output  1  one-cycle pulse; period < NOMINAL-TOL.
REQ-012 SHALL have port late_err  output  1  one-cycle pulse; no tick within NOMINAL+TOL cycles.
REQ-013 SHALL have port err_count  output  8  saturating count of early_err plus late_err events.

Function
REQ-014 SHALL detect an edge in cycle T when tick_in=1 in T and tick_in=0 in T-1 (registered tick_q); a held-high tick_in SHALL produce one edge only.
REQ-015 SHALL maintain a 26-bit counter cnt: on an edge cnt<=1, otherwise cnt<=cnt+1, saturating at NOMINAL+TOL; edges at cycles T0 and T1 therefore give period T1-T0.
REQ-016 SHALL implement states IDLE (no reference edge yet) and RUN (measuring since last edge).
REQ-017 IDLE + edge: cnt<=1, go RUN; no period_valid, no error.
REQ-018 RUN + edge: period<=cnt, period_valid=1 in the next cycle; stay in RUN.
REQ-019 RUN + edge with cnt < NOMINAL-TOL: early_err pulse, consecutive-good counter<=0, locked<=0, err_count+1.
REQ-020 RUN + edge with NOMINAL-TOL <= cnt <= NOMINAL+TOL: good counter+1 saturating at LOCK_N; locked<=1 on the update that reaches LOCK_N.
REQ-021 RUN, no edge, cnt == NOMINAL+TOL: late_err pulse, go IDLE, good counter<=0, locked<=0, err_count+1; period unchanged.
REQ-022 Edge in the same cycle cnt == NOMINAL+TOL SHALL be treated as in-window (edge has priority over timeout); no late_err.
REQ-023 All outputs SHALL be registered; period_valid/early_err/late_err SHALL be high in the cycle following the deciding cycle and for exactly one cycle.
REQ-024 err_count SHALL saturate at 255 and not wrap.
REQ-025 clear=1 SHALL act as reset for state, cnt, good counter, all outputs and err_count, except tick_q which keeps sampling; an edge in the same cycle as clear SHALL be ignored.

Reset
REQ-026 rst=1 SHALL force state=IDLE, cnt=0, tick_q=0, good counter=0, period=0, period_valid=0, locked=0, early_err=0, late_err=0, err_count=0 at the next posedge.
REQ-027 rst SHALL take priority over clear and tick_in; rst asserted mid-measurement SHALL discard the measurement in progress and emit no pulse.
REQ-028 First edge after reset release SHALL only arm measurement (IDLE->RUN).

Verification (NOMINAL=10, TOL=2, LOCK_N=3)
REQ-029 Reset then idle 20 cycles -> all outputs 0, err_count=0.
REQ-030 Single-cycle ticks every 10 cycles x5 -> four period_valid pulses, period=10 each, locked rises with third pulse, no errors.
REQ-031 Locked, next tick after 7 cycles -> period=7, early_err pulse, locked=0, err_count=1; next three 10-cycle periods re-lock.
REQ-032 Tick then none -> late_err pulse 12 cycles after edge plus one, state IDLE; following tick gives no period_valid, next one gives period_valid.
REQ-033 Tick exactly 12 cycles after previous -> period=12, no late_err; tick_in held high 5 cycles -> one edge only.
REQ-034 rst pulse 5 cycles after a tick while locked -> all outputs 0 next cycle, next tick arms only; err_count forced to 255 by 260 early ticks -> stays 255.
